vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line, name, default, meaning, SHALL be:
  H_VISIBLE 800 visible pixels per line; H_FRONT 56 h front porch; H_SYNC 120 h sync width; H_BACK 64 h back porch
  V_VISIBLE 600 visible lines; V_FRONT 37 v front porch; V_SYNC 6 v sync width; V_BACK 23 v back porch
  H_SYNC_POL 1 hsync active level; V_SYNC_POL 1 vsync active level
REQ-002 Derived: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (1040), V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (666).
REQ-003 Ports SHALL be: name, direction, width, meaning.
  i_clk  in  1  the block's one clock, pixel clock (50 MHz for the defaults), rising edge
  i_rst_n  in  1  reset: asynchronous assertion, active-low
  i_pix_en  in  1  pixel advance enable; counters move only when high
  o_h_coord  out  11  horizontal position, 0..H_TOTAL-1
  o_v_coord  out  10  vertical position, 0..V_TOTAL-1
  o_disp_enbl  out  1  high iff position is inside the visible area
  o_hsync  out  1  horizontal sync, polarity per H_SYNC_POL
  o_vsync  out  1  vertical sync, polarity per V_SYNC_POL
  o_line_start  out  1  one-cycle pulse on entering h=0
  o_frame_start  out  1  one-cycle pulse on entering (0,0)

Function
REQ-004 FSM SHALL have two states: IDLE (after reset) and RUN.
REQ-005 IDLE: all outputs hold reset values; first i_clk edge with i_pix_en=1 -> RUN with position (0,0).
REQ-006 RUN, i_pix_en=1: h <- h+1; at h=H_TOTAL-1, h <- 0 and v <- v+1; at (H_TOTAL-1, V_TOTAL-1), position <- (0,0).
REQ-007 RUN, i_pix_en=0: position, o_disp_enbl, o_hsync and o_vsync hold; o_line_start and o_frame_start are 0.
REQ-008 All outputs SHALL be registered; in every cycle they all describe the same position (o_h_coord, o_v_coord). No output path is combinational from an input.
REQ-009 Position changes 1 cycle after the i_pix_en edge that advances it; decodes are aligned to the new position, with no extra lag.
REQ-010 o_disp_enbl = (h < H_VISIBLE) && (v < V_VISIBLE).
REQ-011 o_hsync = H_SYNC_POL when H_VISIBLE+H_FRONT <= h <= H_VISIBLE+H_FRONT+H_SYNC-1 (856..975), else the opposite level.
REQ-012 o_vsync = V_SYNC_POL when V_VISIBLE+V_FRONT <= v <= V_VISIBLE+V_FRONT+V_SYNC-1 (637..642), else the opposite level. The vsync level is independent of h.
REQ-013 o_line_start = 1 for exactly the cycle in which the position becomes h=0, including IDLE->RUN entry.
REQ-014 o_frame_start = 1 for exactly the cycle in which the position becomes (0,0), including IDLE->RUN entry. o_frame_start SHALL imply o_line_start.
REQ-015 Counter arithmetic SHALL be unsigned. Compares SHALL be evaluated at the full counter width. Counters SHALL never exceed TOTAL-1.

Reset
REQ-016 i_rst_n=0 SHALL asynchronously force: state IDLE, o_h_coord=0, o_v_coord=0, o_disp_enbl=0, o_hsync=~H_SYNC_POL, o_vsync=~V_SYNC_POL, o_line_start=0, o_frame_start=0.
REQ-017 Reset asserted mid-frame SHALL abandon the frame immediately; a restart after reset always begins at (0,0) with o_frame_start.
REQ-018 Reset deassertion SHALL take effect on i_clk. No output changes before the first i_pix_en=1 edge after release.

Verification
REQ-019 Release reset, i_pix_en=1 -> next cycle: (0,0), o_disp_enbl=1, o_frame_start=1, o_line_start=1, o_hsync=0, o_vsync=0.
REQ-020 Run one full line -> o_disp_enbl=1 for exactly 800 cycles; o_hsync=1 for h 856..975 (120 cycles); h=1039 is followed by (0,1) with o_line_start=1 and o_frame_start=0.
REQ-021 Run a full frame -> 666*1040 = 692640 cycles between o_frame_start pulses; o_vsync=1 for lines 637..642; (1039,665) is followed by (0,0) with both pulses high.
REQ-022 Toggle i_pix_en 1/0 every cycle -> every output holds during the 0 cycles, pulses last exactly 1 cycle, and the frame period becomes 2*692640 cycles.
REQ-023 Assert i_rst_n=0 at (500,300), between clock edges -> outputs reach reset values without waiting for an i_clk edge; after release, the first i_pix_en=1 edge gives (0,0) with o_frame_start=1.
REQ-024 Set H_SYNC_POL=0 and V_SYNC_POL=0 -> sync outputs are inverted relative to the default build; the reset level of both syncs is 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered display-enable,
// sync and start-of-line/frame decodes, all aligned to the reported position.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BACK     = 64,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    output logic [10:0] o_h_coord,
    output logic [9:0]  o_v_coord,
    output logic        o_disp_enbl,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic        disp_next, hsync_next, vsync_next, line_next, frame_next;

    // Decodes are taken from the next position so every registered output
    // describes the same pixel as the registered coordinates.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        h_next     = o_h_coord;
        v_next     = o_v_coord;
        disp_next  = o_disp_enbl;
        hsync_next = o_hsync;
        vsync_next = o_vsync;
        line_next  = 1'b0;
        frame_next = 1'b0;

        if (i_pix_en) begin
            state_next = RUN;
            if (state == IDLE) begin
                h_next = '0;
                v_next = '0;
            end else if (o_h_coord >= H_LAST) begin
                h_next = '0;
                v_next = (o_v_coord >= V_LAST) ? 10'd0 : o_v_coord + 10'd1;
            end else begin
                h_next = o_h_coord + 11'd1;
            end

            disp_next  = (h_next < H_VIS) && (v_next < V_VIS);
            hsync_next = (h_next >= H_SYNC_FIRST && h_next <= H_SYNC_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_next = (v_next >= V_SYNC_FIRST && v_next <= V_SYNC_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
            line_next  = (h_next == 11'd0);
            frame_next = (h_next == 11'd0) && (v_next == 10'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_h_coord     <= '0;
            o_v_coord     <= '0;
            o_disp_enbl   <= 1'b0;
            o_hsync       <= ~H_SYNC_POL;
            o_vsync       <= ~V_SYNC_POL;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state         <= state_next;
            o_h_coord     <= h_next;
            o_v_coord     <= v_next;
            o_disp_enbl   <= disp_next;
            o_hsync       <= hsync_next;
            o_vsync       <= vsync_next;
            o_line_start  <= line_next;
            o_frame_start <= frame_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-geometry instance (default sync polarity) and a
// default-geometry instance (inverted polarity), both checked every cycle against a frame-count model.
module tb_vga_timing_gen;

    // Small geometry: 17 pixels x 12 lines, hsync h 12..14, vsync v 8..9, frame = 204 cycles.
    localparam int S_HV = 10, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 6,  S_VF = 2, S_VS = 2, S_VB = 2;
    localparam int D_HV = 800, D_HF = 56, D_HS = 120, D_HB = 64;
    localparam int D_VV = 600, D_VF = 37, D_VS = 6,   D_VB = 23;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        disp;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;

    logic [10:0] s_h, d_h;
    logic [9:0]  s_v, d_v;
    logic        s_disp, s_hs, s_vs, s_ls, s_fs;
    logic        d_disp, d_hs, d_vs, d_ls, d_fs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_h_coord(s_h), .o_v_coord(s_v), .o_disp_enbl(s_disp),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_line_start(s_ls), .o_frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut_dflt (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_h_coord(d_h), .o_v_coord(d_v), .o_disp_enbl(d_disp),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_line_start(d_ls), .o_frame_start(d_fs)
    );

    // Model: the position is simply the number of advances since leaving IDLE,
    // folded into (h, v) by division; pulses follow an advance landing on h = 0.
    bit     m_running = 1'b0;
    longint m_n = 0;
    bit     m_pulse = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (pix_en) begin
                if (!m_running) begin
                    m_running = 1'b1;
                    m_n = 0;
                end else begin
                    m_n = m_n + 1;
                end
            end
            m_pulse = pix_en;
        end
    end

    always @(negedge rst_n) begin
        m_running = 1'b0;
        m_n = 0;
        m_pulse = 1'b0;
    end

    function automatic vec_t expect_vec(input int hv, input int hf, input int hs, input int hb,
                                        input int vv, input int vf, input int vs, input int vb,
                                        input bit hp, input bit vp);
        vec_t e;
        int ht, vt, h, v;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        if (!m_running) return e;
        h = int'(m_n % longint'(ht));
        v = int'((m_n / longint'(ht)) % longint'(vt));
        e.h    = 11'(h);
        e.v    = 10'(v);
        e.disp = (h < hv) && (v < vv);
        e.hs   = (h >= hv + hf && h < hv + hf + hs) ? hp : ~hp;
        e.vs   = (v >= vv + vf && v < vv + vf + vs) ? vp : ~vp;
        e.ls   = m_pulse && (h == 0);
        e.fs   = m_pulse && (h == 0) && (v == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        vec_t s_exp, s_act, d_exp, d_act;
        s_exp = expect_vec(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1'b1, 1'b1);
        d_exp = expect_vec(D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB, 1'b0, 1'b0);
        s_act = '{h: s_h, v: s_v, disp: s_disp, hs: s_hs, vs: s_vs, ls: s_ls, fs: s_fs};
        d_act = '{h: d_h, v: d_v, disp: d_disp, hs: d_hs, vs: d_vs, ls: d_ls, fs: d_fs};
        vectors++;
        if (s_act !== s_exp) begin
            miscompares++;
            $display("FAIL small_cycle t=%0t got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                     $time, s_act.h, s_act.v, s_act.disp, s_act.hs, s_act.vs, s_act.ls, s_act.fs,
                     s_exp.h, s_exp.v, s_exp.disp, s_exp.hs, s_exp.vs, s_exp.ls, s_exp.fs);
        end
        vectors++;
        if (d_act !== d_exp) begin
            miscompares++;
            $display("FAIL dflt_cycle t=%0t got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                     $time, d_act.h, d_act.v, d_act.disp, d_act.hs, d_act.vs, d_act.ls, d_act.fs,
                     d_exp.h, d_exp.v, d_exp.disp, d_exp.hs, d_exp.vs, d_exp.ls, d_exp.fs);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive the enable, then observe after the next rising edge.
    task automatic step(input logic en);
        pix_en = en;
        @(negedge clk);
    endtask

    initial begin
        int cnt, de_cnt, hs_cnt, hs_first, hs_last, vs_cnt, fs_cnt;
        logic [10:0] prev_h;
        logic [9:0]  prev_v;
        bit found;

        repeat (3) @(negedge clk);
        check("rst_small_h", 32'(s_h), 0);
        check("rst_small_hsync", 32'(s_hs), 0);
        check("rst_small_vsync", 32'(s_vs), 0);
        check("rst_dflt_hsync", 32'(d_hs), 1);
        check("rst_dflt_vsync", 32'(d_vs), 1);

        rst_n = 1'b1;
        repeat (3) step(1'b0);
        check("idle_hold_fs", 32'(s_fs), 0);
        check("idle_hold_de", 32'(s_disp), 0);

        step(1'b1);
        check("start_h", 32'(s_h), 0);
        check("start_v", 32'(s_v), 0);
        check("start_de", 32'(s_disp), 1);
        check("start_fs", 32'(s_fs), 1);
        check("start_ls", 32'(s_ls), 1);
        check("start_hsync", 32'(s_hs), 0);
        check("start_vsync", 32'(s_vs), 0);
        check("start_dflt_fs", 32'(d_fs), 1);
        check("start_dflt_hsync", 32'(d_hs), 1);

        // One full default-geometry line.
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 1040; i++) begin
            if (d_disp) de_cnt++;
            if (!d_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_h);
                hs_last = int'(d_h);
            end
            step(1'b1);
        end
        check("line_de_cycles", 32'(de_cnt), 800);
        check("line_hsync_cycles", 32'(hs_cnt), 120);
        check("line_hsync_first", 32'(hs_first), 856);
        check("line_hsync_last", 32'(hs_last), 975);
        check("wrap_h", 32'(d_h), 0);
        check("wrap_v", 32'(d_v), 1);
        check("wrap_ls", 32'(d_ls), 1);
        check("wrap_fs", 32'(d_fs), 0);

        // Small-geometry frame boundary and period.
        found = 1'b0; prev_h = '0; prev_v = '0;
        for (int i = 0; i < 300 && !found; i++) begin
            prev_h = s_h; prev_v = s_v;
            step(1'b1);
            found = s_fs;
        end
        check("frame_found", 32'(found), 1);
        check("frame_prev_h", 32'(prev_h), 16);
        check("frame_prev_v", 32'(prev_v), 11);
        check("frame_ls", 32'(s_ls), 1);

        cnt = 0; vs_cnt = 0; found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1'b1);
            cnt++;
            if (s_vs) vs_cnt++;
            found = s_fs;
        end
        check("frame_period", 32'(cnt), 204);
        check("frame_vsync_cycles", 32'(vs_cnt), 34);

        // Enable toggled every cycle doubles the frame period.
        cnt = 0; fs_cnt = 0; found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1'b0);
            cnt++;
            if (s_fs) fs_cnt++;
            step(1'b1);
            cnt++;
            found = s_fs;
        end
        check("toggle_period", 32'(cnt), 408);
        check("toggle_fs_in_gaps", 32'(fs_cnt), 0);

        // Reset asserted mid-frame, between clock edges.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1'b1);
            found = (s_h == 11'd5) && (s_v == 10'd3);
        end
        check("midframe_found", 32'(found), 1);
        pix_en = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_h", 32'(s_h), 0);
        check("async_rst_v", 32'(s_v), 0);
        check("async_rst_de", 32'(s_disp), 0);
        check("async_rst_hsync", 32'(s_hs), 0);
        check("async_rst_dflt_h", 32'(d_h), 0);
        check("async_rst_dflt_vsync", 32'(d_vs), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0);
        check("restart_idle_fs", 32'(s_fs), 0);
        step(1'b1);
        check("restart_h", 32'(s_h), 0);
        check("restart_v", 32'(s_v), 0);
        check("restart_fs", 32'(s_fs), 1);
        check("restart_ls", 32'(s_ls), 1);
        check("restart_de", 32'(s_disp), 1);
        repeat (20) step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
